md_issue_ctrl: RTL and testbench

//  Execute-stage sequencer between the pipeline and the iterative multdiv unit.
//  - Captures mult/div operands and the destination register from the X stage.
//  - Issues a one-cycle ctrl_Mult/ctrl_Div pulse and stalls F/D/X until multdiv raises ready.
//  - Presents one writeback beat: rd=result, or rstatus=code on exception/timeout.

---
 rtl/md_ctrl_pkg.sv | 19 +
 rtl/md_timeout_counter.sv | 43 ++++
 rtl/md_issue_ctrl.sv | 167 ++++++++++++++++
 tb/tb_md_issue_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/md_ctrl_pkg.sv
// Shared constants for the multdiv issue sequencer: FSM encodings and
// default writeback codes for the rstatus register.
package md_ctrl_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Default parameter values for md_issue_ctrl
  localparam int unsigned WIDTH_DEF     = 32;
  localparam int unsigned RS_REG_DEF    = 30;
  localparam int unsigned MULT_CODE_DEF = 4;
  localparam int unsigned DIV_CODE_DEF  = 5;
  localparam int unsigned TOUT_CODE_DEF = 6;
  localparam int unsigned TIMEOUT_DEF   = 64;

endpackage

// File: rtl/md_timeout_counter.sv
// WAIT-cycle counter for the multdiv sequencer. Cleared while the start
// pulse is out, counts once per enabled cycle. tc_o flags the enabled cycle
// on which the count reaches LIMIT, so the owner can leave on that same cycle
// after exactly LIMIT enabled cycles.
module md_timeout_counter
  import md_ctrl_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_DEF
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned   CW   = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count_q, count_d;

  // Clear has priority over counting.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = en_i & (count_q == LAST);

endmodule

// File: rtl/md_issue_ctrl.sv
// Execute-stage sequencer for the iterative multdiv unit: latches operands,
// fires one start pulse, stalls the front end while multdiv works, then
// presents a single writeback beat (result, exception code or timeout code).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no op in flight; a valid mul/div in X starts one
// ISSUE | one cycle: start pulse to multdiv, counter cleared
// WAIT  | stalled, waiting for md_ready or the timeout
// DONE  | one cycle: writeback beat, instruction leaves X
module md_issue_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned RS_REG    = RS_REG_DEF,
  parameter int unsigned MULT_CODE = MULT_CODE_DEF,
  parameter int unsigned DIV_CODE  = DIV_CODE_DEF,
  parameter int unsigned TOUT_CODE = TOUT_CODE_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             ex_valid,
  input  logic             ex_is_mul,
  input  logic             ex_is_div,
  input  logic [WIDTH-1:0] ex_opA,
  input  logic [WIDTH-1:0] ex_opB,
  input  logic [4:0]       ex_rd,
  input  logic             flush,
  output logic [WIDTH-1:0] md_opA,
  output logic [WIDTH-1:0] md_opB,
  output logic             md_ctrl_mult,
  output logic             md_ctrl_div,
  input  logic [WIDTH-1:0] md_result,
  input  logic             md_except,
  input  logic             md_ready,
  output logic             stall,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data
);

  localparam logic [4:0]       RS_REG_W  = 5'(RS_REG);
  localparam logic [WIDTH-1:0] MULT_W    = WIDTH'(MULT_CODE);
  localparam logic [WIDTH-1:0] DIV_W     = WIDTH'(DIV_CODE);
  localparam logic [WIDTH-1:0] TOUT_W    = WIDTH'(TOUT_CODE);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] opa_q, opb_q, result_q;
  logic [4:0]       rd_q;
  logic             is_mul_q, except_q, tout_q;

  logic start, in_idle, in_issue, in_wait, in_done, tc, err;

  assign start    = ex_valid & (ex_is_mul | ex_is_div) & ~flush;
  assign in_idle  = (state_q == ST_IDLE);
  assign in_issue = (state_q == ST_ISSUE);
  assign in_wait  = (state_q == ST_WAIT);
  assign in_done  = (state_q == ST_DONE);

  md_timeout_counter #(
    .LIMIT (TIMEOUT)
  ) u_tout (
    .clock   (clock),
    .resetn  (resetn),
    .clear_i (in_issue),
    .en_i    (in_wait),
    .tc_o    (tc)
  );

  // Next-state logic; flush aborts anything not yet completed, and md_ready
  // is only looked at in WAIT because it can still be high from the last op.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_ISSUE;
      ST_ISSUE: state_d = flush ? ST_IDLE : ST_WAIT;
      ST_WAIT: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (md_ready || tc) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand / destination latch, loaded only when a new op is accepted.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      opa_q    <= '0;
      opb_q    <= '0;
      rd_q     <= '0;
      is_mul_q <= 1'b0;
    end else if (in_idle && start) begin
      opa_q    <= ex_opA;
      opb_q    <= ex_opB;
      rd_q     <= ex_rd;
      is_mul_q <= ex_is_mul;
    end
  end

  // Completion capture: ready beats the timeout when both land together.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      result_q <= '0;
      except_q <= 1'b0;
      tout_q   <= 1'b0;
    end else if (in_wait && !flush) begin
      if (md_ready) begin
        result_q <= md_result;
        except_q <= md_except;
        tout_q   <= 1'b0;
      end else if (tc) begin
        except_q <= 1'b0;
        tout_q   <= 1'b1;
      end
    end
  end

  assign md_opA       = opa_q;
  assign md_opB       = opb_q;
  assign md_ctrl_mult = in_issue & is_mul_q;
  assign md_ctrl_div  = in_issue & ~is_mul_q;

  // Stall starts combinationally on X-entry and drops the cycle a flush hits.
  always_comb begin
    stall = 1'b0;
    if (in_idle) begin
      stall = start;
    end else if (in_issue || in_wait) begin
      stall = ~flush;
    end
  end

  assign err = except_q | tout_q;

  // Writeback mux; errors redirect to rstatus, and $0 is never written.
  always_comb begin
    wb_valid = 1'b0;
    wb_rd    = '0;
    wb_data  = '0;
    if (in_done) begin
      wb_valid = err | (rd_q != 5'd0);
      wb_rd    = err ? RS_REG_W : rd_q;
      if (tout_q) begin
        wb_data = TOUT_W;
      end else if (except_q) begin
        wb_data = is_mul_q ? MULT_W : DIV_W;
      end else begin
        wb_data = result_q;
      end
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl with a cycle-indexed stimulus runner.
module tb_md_issue_ctrl;

  logic        clock, resetn;
  logic        ex_valid, ex_is_mul, ex_is_div, flush;
  logic [31:0] ex_opA, ex_opB, md_result, md_opA, md_opB, wb_data;
  logic [4:0]  ex_rd, wb_rd;
  logic        md_ctrl_mult, md_ctrl_div, md_except, md_ready, stall, wb_valid;

  int n_checks = 0;
  int n_pass   = 0;

  // Observations from run_op
  int          o_nmul, o_ndiv, o_pulse_cyc, o_nstall, o_last_stall, o_nwb, o_wb_cyc;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data, o_opa, o_opb;

  md_issue_ctrl dut (
    .clock(clock), .resetn(resetn),
    .ex_valid(ex_valid), .ex_is_mul(ex_is_mul), .ex_is_div(ex_is_div),
    .ex_opA(ex_opA), .ex_opB(ex_opB), .ex_rd(ex_rd), .flush(flush),
    .md_opA(md_opA), .md_opB(md_opB),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .md_result(md_result), .md_except(md_except), .md_ready(md_ready),
    .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic idle_inputs();
    ex_valid = 0; ex_is_mul = 0; ex_is_div = 0; flush = 0;
    ex_opA = 0; ex_opB = 0; ex_rd = 0;
    md_result = 0; md_except = 0; md_ready = 0;
  endtask

  // Cycle 0 is X-entry. X holds its instruction while stall was high.
  task automatic run_op(input logic mul, input logic div, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int ready_cyc,
                        input logic exc, input logic [31:0] res, input int flush_cyc,
                        input int ncyc);
    logic prev_stall;
    prev_stall = 1'b0;
    o_nmul = 0; o_ndiv = 0; o_pulse_cyc = -1; o_nstall = 0; o_last_stall = -1;
    o_nwb = 0; o_wb_cyc = -1; o_wb_rd = 0; o_wb_data = 0; o_opa = 0; o_opb = 0;
    for (int c = 0; c < ncyc; c++) begin
      ex_valid  = (c == 0) || prev_stall;
      ex_is_mul = mul; ex_is_div = div; ex_opA = a; ex_opB = b; ex_rd = rd;
      flush     = (c == flush_cyc);
      md_ready  = (c == ready_cyc);
      md_except = (c == ready_cyc) && exc;
      md_result = (c == ready_cyc) ? res : 32'hDEAD_BEEF;
      #1;
      if (md_ctrl_mult) begin o_nmul++; o_pulse_cyc = c; end
      if (md_ctrl_div)  begin o_ndiv++; o_pulse_cyc = c; end
      if (stall) begin o_nstall++; o_last_stall = c; end
      if (wb_valid) begin o_nwb++; o_wb_cyc = c; o_wb_rd = wb_rd; o_wb_data = wb_data; end
      if (c == 3) begin o_opa = md_opA; o_opb = md_opB; end
      prev_stall = stall;
      @(posedge clock); #1;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 0;
    #3;
    n_checks++; if ({stall, wb_valid, md_ctrl_mult, md_ctrl_div} !== 4'b0) $display("FAIL reset_flags got=%b exp=0000", {stall, wb_valid, md_ctrl_mult, md_ctrl_div}); else n_pass++;
    n_checks++; if ({md_opA, md_opB, wb_data, wb_rd} !== '0) $display("FAIL reset_data got opA=%h opB=%h wbd=%h wbrd=%0d exp=0", md_opA, md_opB, wb_data, wb_rd); else n_pass++;
    repeat (2) @(posedge clock);
    #1 resetn = 1;
    @(posedge clock); #2;
    n_checks++; if (stall !== 1'b0) $display("FAIL reset_idle_stall got=%b exp=0", stall); else n_pass++;
    @(posedge clock); #1;
  endtask

  task automatic test_mul_basic();
    run_op(1, 0, 32'd7, 32'hFFFF_FFFD, 5'd5, 35, 0, 32'hFFFF_FFEB, -1, 42);
    n_checks++; if (o_nmul !== 1 || o_pulse_cyc !== 1) $display("FAIL mul_pulse got n=%0d cyc=%0d exp n=1 cyc=1", o_nmul, o_pulse_cyc); else n_pass++;
    n_checks++; if (o_ndiv !== 0) $display("FAIL mul_no_div got=%0d exp=0", o_ndiv); else n_pass++;
    n_checks++; if (o_nstall !== 36 || o_last_stall !== 35) $display("FAIL mul_stall got n=%0d last=%0d exp n=36 last=35", o_nstall, o_last_stall); else n_pass++;
    n_checks++; if (o_opa !== 32'd7 || o_opb !== 32'hFFFF_FFFD) $display("FAIL mul_operands got A=%h B=%h exp A=7 B=fffffffd", o_opa, o_opb); else n_pass++;
    n_checks++; if (o_nwb !== 1 || o_wb_cyc !== 36) $display("FAIL mul_wb_timing got n=%0d cyc=%0d exp n=1 cyc=36", o_nwb, o_wb_cyc); else n_pass++;
    n_checks++; if (o_wb_rd !== 5'd5 || o_wb_data !== 32'hFFFF_FFEB) $display("FAIL mul_wb_value got rd=%0d data=%h exp rd=5 data=ffffffeb", o_wb_rd, o_wb_data); else n_pass++;
  endtask

  task automatic test_div_except();
    run_op(0, 1, 32'd10, 32'd0, 5'd8, 20, 1, 32'h1234_5678, -1, 25);
    n_checks++; if (o_ndiv !== 1 || o_nmul !== 0) $display("FAIL divz_pulse got div=%0d mul=%0d exp div=1 mul=0", o_ndiv, o_nmul); else n_pass++;
    n_checks++; if (o_nwb !== 1 || o_wb_cyc !== 21) $display("FAIL divz_wb_timing got n=%0d cyc=%0d exp n=1 cyc=21", o_nwb, o_wb_cyc); else n_pass++;
    n_checks++; if (o_wb_rd !== 5'd30 || o_wb_data !== 32'd5) $display("FAIL divz_wb_value got rd=%0d data=%0d exp rd=30 data=5", o_wb_rd, o_wb_data); else n_pass++;
  endtask

  task automatic test_flush_wait();
    run_op(1, 0, 32'd3, 32'd4, 5'd6, 33, 0, 32'd12, 10, 40);
    n_checks++; if (o_nstall !== 10 || o_last_stall !== 9) $display("FAIL flush_stall got n=%0d last=%0d exp n=10 last=9", o_nstall, o_last_stall); else n_pass++;
    n_checks++; if (o_nwb !== 0) $display("FAIL flush_no_wb got=%0d exp=0", o_nwb); else n_pass++;
    n_checks++; if (o_nmul !== 1) $display("FAIL flush_single_issue got=%0d exp=1", o_nmul); else n_pass++;
  endtask

  task automatic test_timeout();
    run_op(0, 1, 32'd9, 32'd3, 5'd7, -1, 0, 32'd0, -1, 75);
    n_checks++; if (o_nstall !== 66 || o_last_stall !== 65) $display("FAIL tout_stall got n=%0d last=%0d exp n=66 last=65", o_nstall, o_last_stall); else n_pass++;
    n_checks++; if (o_nwb !== 1 || o_wb_cyc !== 66) $display("FAIL tout_wb_timing got n=%0d cyc=%0d exp n=1 cyc=66", o_nwb, o_wb_cyc); else n_pass++;
    n_checks++; if (o_wb_rd !== 5'd30 || o_wb_data !== 32'd6) $display("FAIL tout_wb_value got rd=%0d data=%0d exp rd=30 data=6", o_wb_rd, o_wb_data); else n_pass++;
    n_checks++; if (o_ndiv !== 1) $display("FAIL tout_back_idle got pulses=%0d exp=1", o_ndiv); else n_pass++;
  endtask

  task automatic test_ready_vs_timeout();
    run_op(0, 1, 32'd50, 32'd5, 5'd9, 65, 0, 32'd123, -1, 70);
    n_checks++; if (o_nwb !== 1 || o_wb_cyc !== 66) $display("FAIL race_wb_timing got n=%0d cyc=%0d exp n=1 cyc=66", o_nwb, o_wb_cyc); else n_pass++;
    n_checks++; if (o_wb_rd !== 5'd9 || o_wb_data !== 32'd123) $display("FAIL race_ready_wins got rd=%0d data=%0d exp rd=9 data=123", o_wb_rd, o_wb_data); else n_pass++;
  endtask

  task automatic test_rd_zero();
    run_op(1, 0, 32'd2, 32'd2, 5'd0, 5, 0, 32'd4, -1, 10);
    n_checks++; if (o_nwb !== 0) $display("FAIL rd0_no_wb got=%0d exp=0", o_nwb); else n_pass++;
    n_checks++; if (o_nstall !== 6) $display("FAIL rd0_stall got=%0d exp=6", o_nstall); else n_pass++;
  endtask

  task automatic test_flush_done();
    run_op(1, 0, 32'd11, 32'd7, 5'd4, 4, 0, 32'd77, 5, 9);
    n_checks++; if (o_nwb !== 1 || o_wb_cyc !== 5 || o_wb_data !== 32'd77 || o_wb_rd !== 5'd4) $display("FAIL flush_done_wb got n=%0d cyc=%0d rd=%0d data=%0d exp n=1 cyc=5 rd=4 data=77", o_nwb, o_wb_cyc, o_wb_rd, o_wb_data); else n_pass++;
  endtask

  task automatic test_mul_priority();
    run_op(1, 1, 32'h7FFF_FFFF, 32'd2, 5'd12, 3, 1, 32'd0, -1, 7);
    n_checks++; if (o_nmul !== 1 || o_ndiv !== 0) $display("FAIL prio_pulse got mul=%0d div=%0d exp mul=1 div=0", o_nmul, o_ndiv); else n_pass++;
    n_checks++; if (o_wb_rd !== 5'd30 || o_wb_data !== 32'd4) $display("FAIL prio_mult_code got rd=%0d data=%0d exp rd=30 data=4", o_wb_rd, o_wb_data); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int nwb, wb1_cyc, wb2_cyc, div_cyc;
    logic [31:0] wb1_data, wb2_data, opb_seen;
    logic [4:0]  wb1_rd, wb2_rd;
    nwb = 0; wb1_cyc = -1; wb2_cyc = -1; div_cyc = -1;
    wb1_data = 0; wb2_data = 0; wb1_rd = 0; wb2_rd = 0; opb_seen = 0;
    for (int c = 0; c < 15; c++) begin
      if (c <= 6) begin
        ex_valid = 1; ex_is_mul = 1; ex_is_div = 0; ex_opA = 6; ex_opB = 7; ex_rd = 2;
      end else if (c <= 10) begin
        ex_valid = 1; ex_is_mul = 0; ex_is_div = 1; ex_opA = 100; ex_opB = 7; ex_rd = 3;
      end else begin
        ex_valid = 0; ex_is_mul = 0; ex_is_div = 0;
      end
      md_ready  = (c >= 5);
      md_result = (c < 5) ? 32'hDEAD_BEEF : (c < 8) ? 32'd42 : 32'd14;
      #1;
      if (md_ctrl_div) div_cyc = c;
      if (c == 9) opb_seen = md_opB;
      if (wb_valid) begin
        nwb++;
        if (nwb == 1) begin wb1_cyc = c; wb1_rd = wb_rd; wb1_data = wb_data; end
        else begin wb2_cyc = c; wb2_rd = wb_rd; wb2_data = wb_data; end
      end
      @(posedge clock); #1;
    end
    idle_inputs();
    n_checks++; if (wb1_cyc !== 6 || wb1_rd !== 5'd2 || wb1_data !== 32'd42) $display("FAIL b2b_first_wb got cyc=%0d rd=%0d data=%0d exp cyc=6 rd=2 data=42", wb1_cyc, wb1_rd, wb1_data); else n_pass++;
    n_checks++; if (div_cyc !== 8) $display("FAIL b2b_div_pulse got cyc=%0d exp cyc=8", div_cyc); else n_pass++;
    n_checks++; if (opb_seen !== 32'd7) $display("FAIL b2b_div_opB got=%0d exp=7", opb_seen); else n_pass++;
    n_checks++; if (nwb !== 2 || wb2_cyc !== 10 || wb2_rd !== 5'd3 || wb2_data !== 32'd14) $display("FAIL b2b_second_wb got n=%0d cyc=%0d rd=%0d data=%0d exp n=2 cyc=10 rd=3 data=14", nwb, wb2_cyc, wb2_rd, wb2_data); else n_pass++;
  endtask

  task automatic test_async_reset();
    ex_valid = 1; ex_is_mul = 1; ex_opA = 32'hAAAA_5555; ex_opB = 32'h1234; ex_rd = 5'd17;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
    end
    #2;
    n_checks++; if (stall !== 1'b1 || md_opA !== 32'hAAAA_5555) $display("FAIL arst_pre got stall=%b opA=%h exp stall=1 opA=aaaa5555", stall, md_opA); else n_pass++;
    resetn = 0; ex_valid = 0; ex_is_mul = 0;
    #1;
    n_checks++; if ({stall, wb_valid, md_ctrl_mult, md_ctrl_div} !== 4'b0 || {md_opA, md_opB, wb_data, wb_rd} !== '0) $display("FAIL arst_immediate got stall=%b wbv=%b opA=%h opB=%h exp all 0", stall, wb_valid, md_opA, md_opB); else n_pass++;
    @(posedge clock); #1;
    resetn = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (stall !== 1'b0 || md_ctrl_mult !== 1'b0) $display("FAIL arst_idle_%0d got stall=%b mult=%b exp 0 0", c, stall, md_ctrl_mult); else n_pass++;
      @(posedge clock); #1;
    end
    ex_valid = 1; ex_is_mul = 1; ex_opA = 1; ex_opB = 1; ex_rd = 1;
    #1;
    n_checks++; if (stall !== 1'b1) $display("FAIL arst_restart_stall got=%b exp=1", stall); else n_pass++;
    @(posedge clock); #1;
    n_checks++; if (md_ctrl_mult !== 1'b1) $display("FAIL arst_restart_pulse got=%b exp=1", md_ctrl_mult); else n_pass++;
    flush = 1; ex_valid = 0;
    @(posedge clock); #1;
    idle_inputs();
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL issue_flush_idle got=%b exp=0", stall); else n_pass++;
    @(posedge clock); #1;
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_div_except();
    test_flush_wait();
    test_timeout();
    test_ready_vs_timeout();
    test_rd_zero();
    test_flush_done();
    test_mul_priority();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
